vp_bbox_overlay: RTL and testbench
==================================

Name: vp_bbox_overlay

Overview:
- Post-processing stage placed directly downstream of the `vp` binarization output, before `hdmi_out`.
- Each frame, tracks the bounding box of all foreground mask pixels.
- On the next frame, draws that box as a 1-pixel outline over the video.
- Passes video timing through with a fixed delay and exports the latched box coordinates.

Parameters:
- IMG_W, 64, active pixels per line
- IMG_H, 64, active lines per frame
- BOX_COLOR, 24'hFF0000, RGB888 outline colour
- XW, $clog2(IMG_W), x coordinate width (derived localparam)
- YW, $clog2(IMG_H), y coordinate width (derived localparam)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- de_in  in  1  data enable
- h_sync_in  in  1  horizontal sync
- v_sync_in  in  1  vertical sync
- pixel_in  in  24  RGB888 background video
- mask_in  in  1  foreground flag, qualified by de_in
- sw_en  in  1  overlay enable (0 = pass-through, box still tracked)
- de_out  out  1  delayed de_in
- h_sync_out  out  1  delayed h_sync_in
- v_sync_out  out  1  delayed v_sync_in
- pixel_out  out  24  video with overlay
- bbox_valid  out  1  latched box holds data from the previous full frame
- x_min, x_max  out  XW  latched box columns
- y_min, y_max  out  YW  latched box rows

Behaviour:
Reset state:
- Reset is asynchronous, active-low.
- All outputs reset to 0. Counters, accumulators and the found flag clear. armed=0.

Position counters:
- x increments on each de_in=1 cycle and clears on the de_in falling edge.
- y increments on the de_in falling edge and clears on the v_sync_in rising edge.
- x saturates at IMG_W-1; y saturates at IMG_H-1. Oversized input frames never wrap.

Accumulate (de_in=1 and mask_in=1):
- If found=0: load min=max=(x,y) and set found=1.
- Otherwise: x_min/y_min = min(current, acc); x_max/y_max = max(current, acc).

Frame end (v_sync_in rising edge, detected with a 1-cycle registered copy of v_sync_in):
- If armed=1: copy the accumulators to the outputs and set bbox_valid=found.
- If armed=0: leave the outputs unchanged.
- In both cases: clear the accumulators and found, then set armed=1.
- The first partial frame after reset is therefore discarded.

Outputs:
- Outputs hold their values for the whole next frame and change only at a frame-end edge.
- A frame with no mask pixel gives bbox_valid=0. Coordinates then hold their previous values and are don't-care.

Video path:
- Fixed 2-cycle latency from {de,h_sync,v_sync,pixel}_in to {de,h_sync,v_sync,pixel}_out.
  - Stage 1 registers the inputs plus x, y.
  - Stage 2 registers the overlay mux output.

Overlay condition, evaluated on the stage-1 x/y. Border = sw_en & bbox_valid & de & (
- (x==x_min or x==x_max) and y_min<=y<=y_max, or
- (y==y_min or y==y_max) and x_min<=x<=x_max ).
- Border pixels output BOX_COLOR. All other pixels output the delayed pixel_in.
- When de=0, pixel_out = 0.

Boundary cases:
- Single-pixel box (min==max): exactly one BOX_COLOR pixel.
- A box touching the image edge still draws its edge column/row.
- Frame-end latch and accumulation never coincide, since de_in=0 during v_sync.
- Reset mid-frame: outputs go to 0 immediately; tracking restarts after two v_sync rising edges.

Decomposition:
- Shared package `vp_pkg`: RGB888 pixel type, IMG_W/IMG_H defaults, colour constants (BOX_COLOR default).
- One natural sub-module: `vp_pos_counter`, which generates x/y/frame_end from de and v_sync. It is reusable by the other vp stages.
- Min/max accumulation and the overlay mux stay in the top module.

Test Plan:
- 64x64 frame, mask at the single pixel (10,20), two frames → frame 2: bbox_valid=1, x_min=x_max=10, y_min=y_max=20; exactly one output pixel = FF0000, at (10,20).
- Mask rectangle x 5..40, y 3..50 → x_min=5, x_max=40, y_min=3, y_max=50; next frame: row 3 cols 5..40 red, col 40 rows 3..50 red, pixel (20,20) = input pixel.
- Frame with mask all zero after a valid frame → bbox_valid=0, pixel_out equals pixel_in delayed 2 cycles for the whole frame.
- sw_en=0 with a valid box → pixel_out = pixel_in (2-cycle delay), coordinate outputs still updated.
- Assert rst_n low mid-frame → all outputs 0 asynchronously; first full frame after the first post-reset v_sync produces bbox_valid only at the second v_sync edge.
- Mask at (63,63) and (0,0) → x_min=0, x_max=63, y_min=0, y_max=63; full image border drawn; de/sync outputs match inputs delayed exactly 2 clk.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared definitions for the vp video-processing stages.
// Holds the RGB888 pixel type, default image geometry and colour constants.
package vp_pkg;

    localparam int unsigned IMG_W_DEF = 64;
    localparam int unsigned IMG_H_DEF = 64;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam rgb888_t COLOR_BLACK   = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb888_t COLOR_RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb888_t BOX_COLOR_DEF = COLOR_RED;

endpackage

// File: rtl/vp_pos_counter.sv
// Pixel position tracker for the vp stages.
// Ports: clk, rst_n (async active-low), de / v_sync (input timing),
//        x / y (position of the pixel currently on de, saturating),
//        frame_end_c (combinational one-cycle pulse on the v_sync rising edge).
module vp_pos_counter
    import vp_pkg::*;
#(
    parameter  int unsigned IMG_W = IMG_W_DEF,
    parameter  int unsigned IMG_H = IMG_H_DEF,
    localparam int unsigned XW    = $clog2(IMG_W),
    localparam int unsigned YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          de,
    input  logic          v_sync,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          frame_end_c
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic de_q;
    logic vs_q;
    logic de_fall_c;

    assign de_fall_c   = de_q & ~de;
    assign frame_end_c = v_sync & ~vs_q;

    // Counters saturate so oversized frames pile up on the last column/row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q <= 1'b0;
            vs_q <= 1'b0;
            x    <= '0;
            y    <= '0;
        end else begin
            de_q <= de;
            vs_q <= v_sync;
            if (de) begin
                if (x != X_LAST) x <= x + XW'(1);
            end else if (de_fall_c) begin
                x <= '0;
            end
            if (frame_end_c) begin
                y <= '0;
            end else if (de_fall_c && (y != Y_LAST)) begin
                y <= y + YW'(1);
            end
        end
    end

endmodule

// File: rtl/vp_bbox_overlay.sv
// Bounding-box overlay stage: tracks the box enclosing all foreground mask
// pixels of a frame and outlines it (1 pixel wide) over the following frame.
// Ports: clk, rst_n; de_in/h_sync_in/v_sync_in/pixel_in video in; mask_in
//        foreground flag; sw_en overlay enable; *_out video delayed 2 clocks;
//        bbox_valid/x_min/x_max/y_min/y_max box latched at the last frame end.
module vp_bbox_overlay
    import vp_pkg::*;
#(
    parameter  int unsigned IMG_W     = IMG_W_DEF,
    parameter  int unsigned IMG_H     = IMG_H_DEF,
    parameter  rgb888_t     BOX_COLOR = BOX_COLOR_DEF,
    localparam int unsigned XW        = $clog2(IMG_W),
    localparam int unsigned YW        = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          de_in,
    input  logic          h_sync_in,
    input  logic          v_sync_in,
    input  rgb888_t       pixel_in,
    input  logic          mask_in,
    input  logic          sw_en,
    output logic          de_out,
    output logic          h_sync_out,
    output logic          v_sync_out,
    output rgb888_t       pixel_out,
    output logic          bbox_valid,
    output logic [XW-1:0] x_min,
    output logic [XW-1:0] x_max,
    output logic [YW-1:0] y_min,
    output logic [YW-1:0] y_max
);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          frame_end_c;

    vp_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .clk         (clk),
        .rst_n       (rst_n),
        .de          (de_in),
        .v_sync      (v_sync_in),
        .x           (x),
        .y           (y),
        .frame_end_c (frame_end_c)
    );

    logic [XW-1:0] acc_x_min;
    logic [XW-1:0] acc_x_max;
    logic [YW-1:0] acc_y_min;
    logic [YW-1:0] acc_y_max;
    logic          found;
    logic          armed;

    // Accumulate the running box; at frame end publish it (once armed) and restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_x_min  <= '0;
            acc_x_max  <= '0;
            acc_y_min  <= '0;
            acc_y_max  <= '0;
            found      <= 1'b0;
            armed      <= 1'b0;
            bbox_valid <= 1'b0;
            x_min      <= '0;
            x_max      <= '0;
            y_min      <= '0;
            y_max      <= '0;
        end else if (frame_end_c) begin
            if (armed) begin
                bbox_valid <= found;
                // An empty frame keeps the old coordinates; bbox_valid flags them stale.
                if (found) begin
                    x_min <= acc_x_min;
                    x_max <= acc_x_max;
                    y_min <= acc_y_min;
                    y_max <= acc_y_max;
                end
            end
            acc_x_min <= '0;
            acc_x_max <= '0;
            acc_y_min <= '0;
            acc_y_max <= '0;
            found     <= 1'b0;
            armed     <= 1'b1;
        end else if (de_in && mask_in) begin
            if (!found) begin
                acc_x_min <= x;
                acc_x_max <= x;
                acc_y_min <= y;
                acc_y_max <= y;
                found     <= 1'b1;
            end else begin
                if (x < acc_x_min) acc_x_min <= x;
                if (x > acc_x_max) acc_x_max <= x;
                if (y < acc_y_min) acc_y_min <= y;
                if (y > acc_y_max) acc_y_max <= y;
            end
        end
    end

    logic          de_s1;
    logic          hs_s1;
    logic          vs_s1;
    rgb888_t       pix_s1;
    logic [XW-1:0] x_s1;
    logic [YW-1:0] y_s1;

    // Stage 1: register video and its position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_s1  <= 1'b0;
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            pix_s1 <= COLOR_BLACK;
            x_s1   <= '0;
            y_s1   <= '0;
        end else begin
            de_s1  <= de_in;
            hs_s1  <= h_sync_in;
            vs_s1  <= v_sync_in;
            pix_s1 <= pixel_in;
            x_s1   <= x;
            y_s1   <= y;
        end
    end

    logic    on_col_c;
    logic    on_row_c;
    logic    border_c;
    rgb888_t pix_next_c;

    // Overlay mux: outline pixels take the box colour, blanking is forced black.
    always_comb begin
        on_col_c   = ((x_s1 == x_min) || (x_s1 == x_max)) && (y_s1 >= y_min) && (y_s1 <= y_max);
        on_row_c   = ((y_s1 == y_min) || (y_s1 == y_max)) && (x_s1 >= x_min) && (x_s1 <= x_max);
        border_c   = sw_en & bbox_valid & de_s1 & (on_col_c | on_row_c);
        pix_next_c = COLOR_BLACK;
        if (border_c) begin
            pix_next_c = BOX_COLOR;
        end else if (de_s1) begin
            pix_next_c = pix_s1;
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_out     <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            pixel_out  <= COLOR_BLACK;
        end else begin
            de_out     <= de_s1;
            h_sync_out <= hs_s1;
            v_sync_out <= vs_s1;
            pixel_out  <= pix_next_c;
        end
    end

endmodule

// File: tb/tb_vp_bbox_overlay.sv
// Self-checking bench for vp_bbox_overlay: random video with scripted and
// random mask frames, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_vp_bbox_overlay;

    localparam int W      = 64;
    localparam int H      = 64;
    localparam int MAXW   = W + 4;
    localparam int MAXH   = H + 4;
    localparam int HBLANK = 6;
    localparam logic [23:0] RED = 24'hFF0000;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        de_in     = 1'b0;
    logic        h_sync_in = 1'b0;
    logic        v_sync_in = 1'b0;
    logic [23:0] pixel_in  = 24'h0;
    logic        mask_in   = 1'b0;
    logic        sw_en     = 1'b0;
    logic        de_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic [23:0] pixel_out;
    logic        bbox_valid;
    logic [5:0]  x_min;
    logic [5:0]  x_max;
    logic [5:0]  y_min;
    logic [5:0]  y_max;

    vp_bbox_overlay dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .de_in      (de_in),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .pixel_in   (pixel_in),
        .mask_in    (mask_in),
        .sw_en      (sw_en),
        .de_out     (de_out),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .pixel_out  (pixel_out),
        .bbox_valid (bbox_valid),
        .x_min      (x_min),
        .x_max      (x_max),
        .y_min      (y_min),
        .y_max      (y_max)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: the mask of the frame being sent, the box found in
    // the last completed frame, and the box currently shown.
    bit          mask_img [MAXH][MAXW];
    bit          armed_m    = 1'b0;
    bit          pend_valid = 1'b0;
    int          pend_x0, pend_x1, pend_y0, pend_y1;
    bit          lat_valid  = 1'b0;
    int          lat_x0 = 0, lat_x1 = 0, lat_y0 = 0, lat_y1 = 0;
    logic [26:0] exp_d1 = '0;
    logic [26:0] exp_d2 = '0;
    int          red_seen = 0, red_exp = 0;
    bit          red_track = 1'b0;

    function automatic int clampv(input int v, input int lim);
        return (v > lim - 1) ? lim - 1 : v;
    endfunction

    function automatic logic [23:0] exp_pixel(input int xm, input int ym, input logic [23:0] p);
        bit on_v;
        bit on_h;
        on_v = (xm == lat_x0 || xm == lat_x1) && ym >= lat_y0 && ym <= lat_y1;
        on_h = (ym == lat_y0 || ym == lat_y1) && xm >= lat_x0 && xm <= lat_x1;
        if (sw_en && lat_valid && (on_v || on_h)) return RED;
        return p;
    endfunction

    function automatic logic [23:0] rand_pix();
        logic [23:0] p;
        p = 24'($urandom);
        if (p == RED) p = p ^ 24'h1;
        return p;
    endfunction

    task automatic clear_mask();
        for (int j = 0; j < MAXH; j++)
            for (int i = 0; i < MAXW; i++)
                mask_img[j][i] = 1'b0;
    endtask

    task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
        for (int j = y0; j <= y1; j++)
            for (int i = x0; i <= x1; i++)
                mask_img[j][i] = 1'b1;
    endtask

    task automatic compute_pend(input int w, input int h);
        pend_x0 = W; pend_x1 = -1; pend_y0 = H; pend_y1 = -1;
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                if (mask_img[j][i]) begin
                    if (clampv(i, W) < pend_x0) pend_x0 = clampv(i, W);
                    if (clampv(i, W) > pend_x1) pend_x1 = clampv(i, W);
                    if (clampv(j, H) < pend_y0) pend_y0 = clampv(j, H);
                    if (clampv(j, H) > pend_y1) pend_y1 = clampv(j, H);
                end
        pend_valid = (pend_x1 >= 0);
    endtask

    // One clock: check the output for the inputs of two cycles ago, then drive.
    task automatic step(input logic de, input logic hs, input logic vs, input logic m,
                        input logic [23:0] p, input int xm, input int ym);
        logic [23:0] ep;
        @(negedge clk);
        chk("video", 64'({de_out, h_sync_out, v_sync_out, pixel_out}), 64'(exp_d2));
        if (de_out && pixel_out == RED) red_seen++;
        ep = de ? exp_pixel(xm, ym, p) : 24'h0;
        if (de && ep == RED) red_exp++;
        exp_d2 = exp_d1;
        exp_d1 = {de, hs, vs, ep};
        de_in = de; h_sync_in = hs; v_sync_in = vs; mask_in = m; pixel_in = p;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 64'({de_out, h_sync_out, v_sync_out, pixel_out, bbox_valid,
                                   x_min, x_max, y_min, y_max}), 64'(0));
        de_in = 0; h_sync_in = 0; v_sync_in = 0; mask_in = 0; pixel_in = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_d1 = '0; exp_d2 = '0;
        armed_m = 0; pend_valid = 0; lat_valid = 0;
        lat_x0 = 0; lat_x1 = 0; lat_y0 = 0; lat_y1 = 0;
        red_track = 0; red_seen = 0; red_exp = 0;
    endtask

    // Frame = v_sync pulse, back porch, then h lines of w pixels with h-blank.
    task automatic send_frame(input int w, input int h, input bit sw, input int rst_line);
        if (red_track) chk("red_count", 64'(red_seen), 64'(red_exp));
        red_seen = 0; red_exp = 0; red_track = 1;
        sw_en = sw;
        if (armed_m) begin
            lat_valid = pend_valid;
            if (pend_valid) begin
                lat_x0 = pend_x0; lat_x1 = pend_x1; lat_y0 = pend_y0; lat_y1 = pend_y1;
            end
        end
        armed_m = 1;
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 24'h0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 24'h0, 0, 0);
        chk("bbox_valid", 64'(bbox_valid), 64'(lat_valid));
        if (lat_valid) begin
            chk("x_min", 64'(x_min), 64'(lat_x0));
            chk("x_max", 64'(x_max), 64'(lat_x1));
            chk("y_min", 64'(y_min), 64'(lat_y0));
            chk("y_max", 64'(y_max), 64'(lat_y1));
        end
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
                if (j == rst_line && i == 20) begin
                    do_reset();
                    return;
                end
                step(1, 0, 0, mask_img[j][i], rand_pix(), clampv(i, W), clampv(j, H));
            end
            for (int k = 0; k < HBLANK; k++)
                step(0, (k == 1 || k == 2), 0, 0, 24'h0, 0, 0);
        end
        compute_pend(w, h);
    endtask

    initial begin
        int rx0, rx1, ry0, ry1;
        clear_mask();
        repeat (2) @(negedge clk);
        chk("reset_state", 64'({de_out, h_sync_out, v_sync_out, pixel_out, bbox_valid,
                                x_min, x_max, y_min, y_max}), 64'(0));
        rst_n = 1'b1;

        // single pixel
        clear_mask(); mask_img[20][10] = 1;
        send_frame(W, H, 1, -1);
        // rectangle; shows the single-pixel box
        clear_mask(); set_rect(5, 40, 3, 50);
        send_frame(W, H, 1, -1);
        // empty mask; shows the rectangle
        clear_mask();
        send_frame(W, H, 1, -1);
        // opposite corners; nothing shown (empty box)
        clear_mask(); mask_img[0][0] = 1; mask_img[63][63] = 1;
        send_frame(W, H, 1, -1);
        // random rectangle with overlay disabled; full-border box tracked only
        clear_mask();
        rx0 = $urandom_range(0, 62); rx1 = $urandom_range(rx0, 63);
        ry0 = $urandom_range(0, 62); ry1 = $urandom_range(ry0, 63);
        set_rect(rx0, rx1, ry0, ry1);
        send_frame(W, H, 0, -1);
        // random scatter; shows the random rectangle
        clear_mask();
        for (int j = 0; j < H; j++)
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 199) == 0) mask_img[j][i] = 1;
        mask_img[$urandom_range(0, 63)][$urandom_range(0, 63)] = 1;
        send_frame(W, H, 1, -1);
        // oversized frame: positions saturate at the last column/row
        clear_mask(); mask_img[65][66] = 1; mask_img[60][2] = 1;
        send_frame(W + 3, H + 2, 1, -1);
        // reset in the middle of a line
        clear_mask(); mask_img[2][30] = 1;
        send_frame(W, H, 1, 5);
        // first post-reset frame is discarded, second latches
        clear_mask();
        rx0 = $urandom_range(0, 62); rx1 = $urandom_range(rx0, 63);
        ry0 = $urandom_range(0, 62); ry1 = $urandom_range(ry0, 63);
        set_rect(rx0, rx1, ry0, ry1);
        send_frame(W, H, 1, -1);
        clear_mask();
        send_frame(W, H, 1, -1);
        // trailing frame edge latches the empty frame
        send_frame(W, 0, 1, -1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 24'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
